// File: rtl/flow_rr_arb.sv
// flow_rr_arb: round-robin arbiter merging N valid/ready upstream channels
// into one registered single-entry valid/ready downstream stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   d_u[N*W]     upstream data, requester i at [i*W +: W]
//   v_u[N]       upstream valid
//   r_u[N]       upstream ready (combinational, at most one bit high)
//   d_d[W]       registered downstream data
//   g_d[IW]      registered source index of d_d
//   v_d          downstream valid
//   r_d          downstream ready
//   l_u[N], l_d  per-beat last flags (only with FLOW_ARB_LAST_EN)
//
// Optional feature macro: FLOW_ARB_LAST_EN
//   When defined, a transfer with l_u[i] = 0 locks arbitration onto i until
//   a transfer with l_u[i] = 1; the pointer advances only on last beats.
module flow_rr_arb #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  d_u,
  input  logic [N-1:0]    v_u,
  output logic [N-1:0]    r_u,
  output logic [W-1:0]    d_d,
  output logic [IW-1:0]   g_d,
  output logic            v_d,
  input  logic            r_d
`ifdef FLOW_ARB_LAST_EN
  ,
  input  logic [N-1:0]    l_u,
  output logic            l_d
`endif
);

  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] ptr_q, ptr_d;

`ifdef FLOW_ARB_LAST_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          last_q, last_d;
`endif

  logic [N-1:0]  elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_next;
  logic          ld;
  logic          up_xfer;
  logic          win_last;

  // Winner search: first eligible requester scanning from ptr with wrap.
  always_comb begin
    int unsigned idx;
    elig      = v_u;
`ifdef FLOW_ARB_LAST_EN
    if (lock_q) begin
      elig = v_u & (N'(1) << lock_idx_q);
    end
`endif
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!win_found && elig[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Handshake: load when the output stage is empty or draining; no grant in reset.
  always_comb begin
    ld       = !valid_q || r_d;
    up_xfer  = !rst && ld && win_found;
    r_u      = '0;
    if (up_xfer) begin
      r_u = N'(1) << win_idx;
    end
    // Wrap by comparison so non-power-of-two N works.
    win_next = (32'(win_idx) == N - 1) ? '0 : win_idx + IW'(1);
`ifdef FLOW_ARB_LAST_EN
    win_last = l_u[win_idx];
`else
    win_last = 1'b1;
`endif
  end

  // Next-state for the output stage, pointer and lock.
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef FLOW_ARB_LAST_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
`endif
    if (up_xfer) begin
      data_d  = d_u[32'(win_idx) * W +: W];
      grant_d = win_idx;
      valid_d = 1'b1;
      if (win_last) begin
        ptr_d = win_next;
      end
`ifdef FLOW_ARB_LAST_EN
      last_d     = win_last;
      lock_d     = !win_last;
      lock_idx_d = win_idx;
`endif
    end else if (valid_q && r_d) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef FLOW_ARB_LAST_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_q     <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef FLOW_ARB_LAST_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
`endif
    end
  end

  assign d_d = data_q;
  assign g_d = grant_q;
  assign v_d = valid_q;
`ifdef FLOW_ARB_LAST_EN
  assign l_d = last_q;
`endif

endmodule
